obi_sram_responder: RTL
=======================

# obi_sram_responder

OBI responder that terminates one slave port of the system crossbar and drives a single-port synchronous SRAM macro. It accepts one request per handshake, adds a configurable number of grant wait states, and returns an in-order `rvalid`/`rdata` response a fixed `MemLatency` cycles after each grant. Addresses outside the bank are completed with zero read data, no SRAM access, and a saturating error count. It is instantiated once per memory bank, on the slave side of `system_xbar`.

## Interface
- `NumWords`, default 8192: bank depth in 32-bit words; must be a power of two; `AddrWidth = $clog2(NumWords)`.
- `BaseAddr`, default 32'h0000_0000: byte base address of the bank; aligned to `NumWords*4`.
- `MemLatency`, default 1: SRAM read latency in cycles, legal range 1..3.
- `WaitStates`, default 0: cycles that `gnt` is withheld after `req` first rises, legal range 0..7.
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `obi_req_i`  in  obi_req_t  fields `req`, `we`, `be[3:0]`, `addr[31:0]`, `wdata[31:0]`, arriving from the crossbar.
- `obi_resp_o`  out  obi_resp_t  fields `gnt`, `rvalid`, `rdata[31:0]`, returned to the crossbar.
- `mem_req_o`  out  1  SRAM chip enable, one cycle per access.
- `mem_we_o`  out  1  SRAM write enable.
- `mem_be_o`  out  4  SRAM byte enables.
- `mem_addr_o`  out  AddrWidth  SRAM word address.
- `mem_wdata_o`  out  32  SRAM write data.
- `mem_rdata_i`  in  32  SRAM read data, valid `MemLatency` cycles after `mem_req_o`.
- `oor_count_o`  out  16  saturating count of out-of-range accesses.

## Operation
- Handshake: a transfer is accepted when `req && gnt` is high in the same cycle. The master holds `req`, `addr`, `we`, `be` and `wdata` stable until `gnt`. There is no `rready`; responses are always consumed.
- Grant FSM, states IDLE and WAIT:
  - When `WaitStates == 0`, `gnt = req` combinationally in IDLE and the FSM never leaves IDLE.
  - When `WaitStates > 0`: in IDLE, `req` loads `wcnt = WaitStates` and moves to WAIT, with `gnt = 0`.
  - In WAIT, `wcnt` decrements each cycle. `gnt = req && (wcnt == 1)`. On grant the FSM returns to IDLE.
  - If `req` drops while in WAIT (protocol violation), the FSM returns to IDLE and `wcnt` clears. No access is made and no response is sent.
- Address decode:
  - `in_range = (addr - BaseAddr) < NumWords*4`, computed in 32-bit unsigned arithmetic so that wrap-around below the base counts as out of range.
  - `mem_addr_o = (addr - BaseAddr)[AddrWidth+1:2]`. Byte offset bits [1:0] are ignored.
- On grant:
  - If in range: `mem_req_o = 1` in the same cycle, and `mem_we_o/be_o/wdata_o` are passed through combinationally.
  - If out of range: `mem_req_o = 0`, and `oor_count_o` increments, saturating at 16'hFFFF.
- Response pipeline:
  - Shift register `MemLatency` deep, with entries {valid, oor}. It is loaded on every grant and advances every cycle.
  - `rvalid` is the tail valid bit.
  - `rdata = oor ? 32'h0 : mem_rdata_i` for reads. Writes also return `rvalid`, and `rdata` is then don't-care but driven to 0.
  - Read/write type is tracked per entry.
- Throughput: with `WaitStates == 0`, one grant per cycle is sustained indefinitely and responses stay strictly in order. No stall is needed, because response depth equals `MemLatency` and responses are never back-pressured.
- When `mem_req_o = 0`, all `mem_*` outputs are driven to 0.

## Timing
- Reset values: `gnt = 0` (`WaitStates > 0`) or `gnt = req` (`WaitStates == 0`; reset does not gate the combinational path). Also `rvalid = 0`, `rdata = 0`, `mem_req_o = 0`, `mem_we_o = 0`, `mem_be_o = 0`, `mem_addr_o = 0`, `mem_wdata_o = 0`, `oor_count_o = 0`. FSM resets to IDLE and the pipeline to all-invalid.
- Reset asserted mid-operation discards pending responses. No `rvalid` appears for transfers granted before reset.
- Grant latency: `WaitStates` cycles after `req` first rises (0 means the same cycle).
- Response latency: `rvalid` appears exactly `MemLatency` cycles after the grant cycle, independent of `WaitStates` and of range.
- Simultaneous grant and tail-out in the same cycle are both serviced. The pipeline shifts and loads together.
- Critical path: `obi_req_i` → `mem_*` is combinational. `mem_rdata_i` → `rdata` has one mux level.

## Test plan
- Reset, then single read at BaseAddr+0x10 (`WaitStates=0`, `MemLatency=1`) → `gnt` same cycle; `mem_addr_o=4`; `rvalid` one cycle later with `rdata` equal to the preloaded word.
- Write 0xDEADBEEF with `be=4'b0011` at word 5, then read word 5 → SRAM sees `be=0011`; read returns 0x0000BEEF when the bank was zero-initialised; two `rvalid`s in order.
- `WaitStates=3`: `req` held from cycle t → `gnt` only at t+3; `rvalid` at t+3+`MemLatency`. Drop `req` at t+1 → no grant, no `mem_req_o`, FSM back to IDLE.
- `MemLatency=3`: back-to-back reads of 8 consecutive words → 8 grants in 8 cycles; 8 `rvalid`s in consecutive cycles starting 3 cycles after the first grant; data in order.
- Access to BaseAddr+NumWords*4, and to BaseAddr−4 → granted; `mem_req_o=0`; `rvalid` with `rdata=0`; `oor_count_o` increments by 1 per access. Force the count to 0xFFFF → it stays at 0xFFFF.
- Assert `rst_i` for one cycle with 2 reads in flight (`MemLatency=2`) → no `rvalid` afterwards; all outputs return to their reset values.

Source files
------------

// File: rtl/obi_sram_responder.sv
// OBI slave port terminating one SRAM bank: grant wait states, range
// decode and a fixed-latency, in-order response pipeline.
package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_sram_responder
  import obi_pkg::*;
#(
  parameter int unsigned NumWords   = 8192,
  parameter logic [31:0] BaseAddr   = 32'h0000_0000,
  parameter int          MemLatency = 1,
  parameter int          WaitStates = 0,
  localparam int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  obi_req_t             obi_req_i,
  output obi_resp_t            obi_resp_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i,
  output logic [15:0]          oor_count_o
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  localparam logic [31:0] Span = 32'(NumWords * 4);
  localparam int Tail = MemLatency - 1;

  state_t state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic gnt, fire, in_range;
  logic [31:0] offset;
  logic [31:0] rdata;
  logic [MemLatency-1:0] vld_q, oor_q, wr_q;
  logic [15:0] oor_cnt_q;

  // Wrap-around below the base lands far above Span
  assign offset   = obi_req_i.addr - BaseAddr;
  assign in_range = offset < Span;
  assign fire     = obi_req_i.req && gnt;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    gnt     = 1'b0;
    if (WaitStates == 0) begin
      state_d = IDLE;
      wcnt_d  = '0;
      gnt     = obi_req_i.req;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (obi_req_i.req) begin
            state_d = WAIT;
            wcnt_d  = 3'(WaitStates);
          end
        end
        WAIT: begin
          if (!obi_req_i.req) begin
            state_d = IDLE;
            wcnt_d  = '0;
          end else if (wcnt_q == 3'd1) begin
            gnt     = 1'b1;
            state_d = IDLE;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req_o   = fire && in_range;
  assign mem_we_o    = mem_req_o && obi_req_i.we;
  assign mem_be_o    = mem_req_o ? obi_req_i.be : '0;
  assign mem_addr_o  = mem_req_o ? offset[AddrWidth+1:2] : '0;
  assign mem_wdata_o = mem_req_o ? obi_req_i.wdata : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      vld_q     <= '0;
      oor_q     <= '0;
      wr_q      <= '0;
      oor_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      vld_q[0] <= fire;
      oor_q[0] <= !in_range;
      wr_q[0]  <= obi_req_i.we;
      for (int i = 1; i < MemLatency; i++) begin
        vld_q[i] <= vld_q[i-1];
        oor_q[i] <= oor_q[i-1];
        wr_q[i]  <= wr_q[i-1];
      end
      if (fire && !in_range && oor_cnt_q != 16'hFFFF)
        oor_cnt_q <= oor_cnt_q + 16'd1;
    end
  end

  assign rdata = (vld_q[Tail] && !oor_q[Tail] && !wr_q[Tail])
               ? mem_rdata_i : '0;

  assign obi_resp_o  = {gnt, vld_q[Tail], rdata};
  assign oor_count_o = oor_cnt_q;

endmodule
